// File: rtl/instruction_prefetch_queue_if.sv
// rtl/instruction_prefetch_queue_if.sv - ROM fetch, redirect and decode-side signals of the prefetch queue
interface instruction_prefetch_queue_if #(
    parameter int ROM_ADDRESS_WIDTH = 16,
    parameter int INSTRUCTION_WIDTH = 64
);
    logic                         iTrigger;
    logic [ROM_ADDRESS_WIDTH-1:0] iInitialCodeAddress;
    logic [ROM_ADDRESS_WIDTH-1:0] oIP;
    logic                         oFetchEnable;
    logic [INSTRUCTION_WIDTH-1:0] iInstruction;
    logic                         iBranchTaken;
    logic [ROM_ADDRESS_WIDTH-1:0] iBranchTarget;
    logic [INSTRUCTION_WIDTH-1:0] oInstruction;
    logic [ROM_ADDRESS_WIDTH-1:0] oInstructionIP;
    logic                         oInstructionAvailable;
    logic                         iInstructionRead;
    logic                         oBusy;
    logic                         oDone;
    logic                         oReturnCode;

    modport slave (
        input  iTrigger, iInitialCodeAddress, iInstruction, iBranchTaken, iBranchTarget, iInstructionRead,
        output oIP, oFetchEnable, oInstruction, oInstructionIP, oInstructionAvailable, oBusy, oDone, oReturnCode
    );

    modport master (
        output iTrigger, iInitialCodeAddress, iInstruction, iBranchTaken, iBranchTarget, iInstructionRead,
        input  oIP, oFetchEnable, oInstruction, oInstructionIP, oInstructionAvailable, oBusy, oDone, oReturnCode
    );
endinterface

// File: rtl/instruction_prefetch_queue.sv
// rtl/instruction_prefetch_queue.sv - DEPTH-entry instruction prefetch queue with redirect and EXIT detection
module instruction_prefetch_queue #(
    parameter int                   ROM_ADDRESS_WIDTH = 16,
    parameter int                   INSTRUCTION_WIDTH = 64,
    parameter int                   OP_LENGTH         = 16,
    parameter int                   DEPTH             = 4,
    parameter logic [OP_LENGTH-1:0] EXIT_OPCODE       = 16'h0001
) (
    input  logic                          Clock,
    input  logic                          Reset,
    instruction_prefetch_queue_if.slave   bus
);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t                         state_q, state_d;
    logic [ROM_ADDRESS_WIDTH-1:0]   pc_q, pc_d, req_ip_q, req_ip_d;
    logic                           inflight_q, inflight_d;
    logic [PW-1:0]                  head_q, head_d, tail_q, tail_d;
    logic [PW:0]                    count_q, count_d;
    logic                           done_q, done_d, rc_q, rc_d;
    logic [INSTRUCTION_WIDTH-1:0]   word_q [DEPTH];
    logic [ROM_ADDRESS_WIDTH-1:0]   ip_q   [DEPTH];

    logic                           fetch, write, pop, flush, wr_en;
    logic                           rtn_exit, head_exit;
    logic [PW:0]                    pending;
    logic [INSTRUCTION_WIDTH-1:0]   head_word;

    assign head_word = word_q[head_q];
    assign head_exit = head_word[INSTRUCTION_WIDTH-1 -: OP_LENGTH] == EXIT_OPCODE;
    // An EXIT word arriving this cycle already blocks the next request.
    assign rtn_exit  = inflight_q && (bus.iInstruction[INSTRUCTION_WIDTH-1 -: OP_LENGTH] == EXIT_OPCODE);
    assign pending   = count_q + (PW+1)'(inflight_q);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_ip_d   = req_ip_q;
        done_d     = 1'b0;
        rc_d       = rc_q;
        flush      = 1'b0;
        fetch      = (state_q == FETCH) && !bus.iTrigger && !bus.iBranchTaken
                     && (pending < FULL) && !rtn_exit;
        pop        = (state_q != IDLE) && (count_q != '0) && bus.iInstructionRead;
        write      = (state_q != IDLE) && inflight_q;
        inflight_d = fetch;
        if (fetch) begin
            req_ip_d = pc_q;
            pc_d     = pc_q + 1'b1;
        end
        if (write && rtn_exit && state_q == FETCH)
            state_d = DRAIN;
        if (state_q == DRAIN && pop && head_exit) begin
            done_d  = 1'b1;
            rc_d    = head_word[0];
            state_d = IDLE;
            flush   = 1'b1;
        end
        // A redirect means any EXIT seen so far was on a wrong path.
        if (state_q != IDLE && bus.iBranchTaken) begin
            flush   = 1'b1;
            pc_d    = bus.iBranchTarget;
            state_d = FETCH;
            done_d  = 1'b0;
            rc_d    = rc_q;
        end
        if (bus.iTrigger) begin
            flush   = 1'b1;
            pc_d    = bus.iInitialCodeAddress;
            state_d = FETCH;
            done_d  = 1'b0;
            rc_d    = 1'b0;
        end
        wr_en   = write && !flush;
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(write);
        count_d = count_q + (PW+1)'(write) - (PW+1)'(pop);
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            req_ip_q   <= '0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            rc_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                ip_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_ip_q   <= req_ip_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            done_q     <= done_d;
            rc_q       <= rc_d;
            if (wr_en) begin
                word_q[tail_q] <= bus.iInstruction;
                ip_q[tail_q]   <= req_ip_q;
            end
        end
    end

    assign bus.oIP                   = pc_q;
    assign bus.oFetchEnable          = fetch;
    assign bus.oInstruction          = head_word;
    assign bus.oInstructionIP        = ip_q[head_q];
    assign bus.oInstructionAvailable = count_q != '0;
    assign bus.oBusy                 = state_q != IDLE;
    assign bus.oDone                 = done_q;
    assign bus.oReturnCode           = rc_q;
endmodule
